// File: rtl/addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  // Signed extremes for an operand width up to 64 bits; callers truncate to width.
  function automatic logic [63:0] signed_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] signed_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/adder_4bit_cla_simple.sv
// 4-bit carry-lookahead slice with group propagate/generate outputs.
module adder_4bit_cla_simple (
  output logic       Propagate,
  output logic       Generate,
  output logic [3:0] Sum,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = A ^ B;
  assign w_g = A & B;

  assign w_c[0] = Cin;
  assign w_c[1] = w_g[0] | (w_p[0] & Cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & Cin);
  assign w_c[4] = Generate | (Propagate & Cin);

  assign Propagate = &w_p;
  assign Generate  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

  assign Sum = w_p ^ w_c[3:0];

endmodule

// File: rtl/addsub_seq16_nibble.sv
// Multi-cycle add/subtract: one CLA slice reused per nibble, carry threaded through a register.
// Define ADDSUB_SAT_EN to clamp overflowing results to the signed max/min.
module addsub_seq16_nibble
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Z,
  output logic             N,
  output logic             V
);

  localparam int NIBBLES = WIDTH / SLICE_W;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam int MSB     = WIDTH - 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_raw;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_z;
  logic             r_n;
  logic             r_v;

  logic               w_p;
  logic               w_g;
  logic [SLICE_W-1:0] w_slice_sum;
  logic [SLICE_W-1:0] w_slice_a;
  logic [SLICE_W-1:0] w_slice_b;
  logic [WIDTH-1:0]   w_raw_next;
  logic [WIDTH-1:0]   w_res;
  logic               w_v;
  logic               w_last;

  assign w_slice_a = r_opa[r_idx*SLICE_W +: SLICE_W];
  assign w_slice_b = r_opb[r_idx*SLICE_W +: SLICE_W];

  adder_4bit_cla_simple u_slice (
    .Propagate (w_p),
    .Generate  (w_g),
    .Sum       (w_slice_sum),
    .A         (w_slice_a),
    .B         (w_slice_b),
    .Cin       (r_carry)
  );

  // On the last nibble this is the complete raw result, used for flags directly.
  always_comb begin
    w_raw_next = r_raw;
    w_raw_next[r_idx*SLICE_W +: SLICE_W] = w_slice_sum;
  end

  assign w_last = (r_idx == IDX_W'(NIBBLES - 1));
  assign w_v    = (r_opa[MSB] == r_opb[MSB]) && (w_raw_next[MSB] != r_opa[MSB]);

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(signed_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(signed_min(WIDTH));
  assign w_res = w_v ? (r_opa[MSB] ? SMIN : SMAX) : w_raw_next;
`else
  assign w_res = w_raw_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_raw   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_opa   <= A;
            r_opb   <= sub ? ~B : B;
            r_carry <= sub;
            r_idx   <= '0;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_raw   <= w_raw_next;
          r_carry <= w_g | (w_p & r_carry);
          if (w_last) begin
            r_idx   <= '0;
            r_sum   <= w_res;
            r_z     <= (w_res == '0);
            r_n     <= w_res[MSB];
            r_v     <= w_v;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready = (r_state != RUN);
  assign done  = (r_state == DONE);
  assign Sum   = r_sum;
  assign Z     = r_z;
  assign N     = r_n;
  assign V     = r_v;

endmodule

// File: tb/tb_addsub_seq16_nibble.sv
// Directed bench for addsub_seq16_nibble; expectations follow ADDSUB_SAT_EN when defined.
module tb_addsub_seq16_nibble;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] A;
  logic [15:0] B;
  logic        ready;
  logic        done;
  logic [15:0] Sum;
  logic        Z;
  logic        N;
  logic        V;

  int n_tests = 0;
  int n_fail  = 0;

  addsub_seq16_nibble #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .ready (ready),
    .done  (done),
    .Sum   (Sum),
    .Z     (Z),
    .N     (N),
    .V     (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts from IDLE, scrambles inputs during RUN, checks done timing and result.
  task automatic run_op(input string tag, input logic s, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] es,
                        input logic ez, input logic en, input logic ev);
    sub = s; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = ~a; B = 16'h5A5A; sub = ~s;
    chk({tag, "_ready_run"}, {31'd0, ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk({tag, "_early_done"}, {31'd0, done}, 32'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_done"},  {31'd0, done},  32'd1);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    chk({tag, "_sum"},   {16'd0, Sum},   {16'd0, es});
    chk({tag, "_z"},     {31'd0, Z},     {31'd0, ez});
    chk({tag, "_n"},     {31'd0, N},     {31'd0, en});
    chk({tag, "_v"},     {31'd0, V},     {31'd0, ev});
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [15:0] a_k;
    logic [15:0] b_k;
    logic [15:0] exp_sum;
    int          n_done;

    rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_sum",   {16'd0, Sum},   32'd0);
    chk("rst_zfl",   {29'd0, Z, N, V}, 32'd0);

    run_op("add1",    1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0);
    run_op("carry",   1'b0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0, 1'b0);
    run_op("subzero", 1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("subneg",  1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0);
`ifdef ADDSUB_SAT_EN
    run_op("ovf_add", 1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    run_op("ovf_sub", 1'b1, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1);
`else
    run_op("ovf_add", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1);
    run_op("ovf_sub", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1);
`endif
    run_op("negadd",  1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b1, 1'b0);

    // Result held through idle cycles
    repeat (2) @(posedge clk);
    #1;
    chk("hold_sum", {16'd0, Sum}, 32'h0000_FFFE);
    chk("hold_n",   {31'd0, N},   32'd1);

    // start held high: accepted at edges 0, 5, 10; done after edges 4, 9, 14
    n_done = 0;
    for (int k = 0; k < 15; k++) begin
      a_k = 16'h1000 + 16'(k) * 16'h0111;
      b_k = 16'(k);
      sub = 1'b0; A = a_k; B = b_k; start = 1'b1;
      @(posedge clk); #1;
      chk("b2b_done", {31'd0, done}, {31'd0, (k % 5 == 4)});
      if (done) begin
        n_done++;
        exp_sum = 16'h1000 + 16'(k - 4) * 16'h0111 + 16'(k - 4);
        chk("b2b_sum", {16'd0, Sum}, {16'd0, exp_sum});
      end
    end
    start = 1'b0;
    chk("b2b_count", n_done, 3);
    @(posedge clk); #1;
    chk("b2b_idle", {30'd0, ready, done}, 32'd2);

    // Reset during the second RUN cycle aborts with no done
    sub = 1'b0; A = 16'h4321; B = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_done",  {31'd0, done},  32'd0);
    chk("abort_sum",   {16'd0, Sum},   32'd0);
    chk("abort_flags", {29'd0, Z, N, V}, 32'd0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("abort_no_done", n_done, 0);

    run_op("after_rst", 1'b1, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
